// File: rtl/random_arbiter.sv
// random_arbiter: round-robin sharing of the random_number generator between NUM_REQ requesters.
// Per-requester repeat suppression is compiled in when RANDOM_NO_REPEAT_EN is defined.
module random_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [3:0]         randomValue,
  output logic               busy,
  output logic               getRandomNumber,
  input  logic [3:0]         randomNumber
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StCapture, StDeliver} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [3:0]      cap_q, cap_d;
  logic [IdxW-1:0] win_idx;
  logic            win_found;
  logic            accept;

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    int unsigned     j;
    logic [IdxW-1:0] jj;
    j         = 0;
    jj        = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IdxW'(j);
      if (!win_found && req[jj]) begin
        win_found = 1'b1;
        win_idx   = jj;
      end
    end
  end

`ifdef RANDOM_NO_REPEAT_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] MaxRetryC = RetryW'(MAX_RETRY);

  logic [RetryW-1:0] retry_q, retry_d;
  logic [3:0]        last_val_q [NUM_REQ];

  // A repeat is tolerated once the retry budget is spent.
  assign accept = (randomNumber != last_val_q[owner_q]) || (retry_q >= MaxRetryC);

  always_comb begin
    retry_d = retry_q;
    if (state_q == StIdle && win_found) retry_d = '0;
    else if (state_q == StCapture && !accept) retry_d = retry_q + RetryW'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      retry_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) last_val_q[i] <= 4'hF;
    end else begin
      retry_q <= retry_d;
      if (state_q == StDeliver) last_val_q[owner_q] <= cap_q;
    end
  end
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          owner_d = win_idx;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        if (accept) begin
          cap_d   = randomNumber;
          state_d = StDeliver;
        end else begin
          state_d = StFetch;
        end
      end
      StDeliver: begin
        ptr_d   = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == StDeliver) grant[owner_q] = 1'b1;
  end

  // cap_q only changes on an accepted capture, so it holds the last delivered digit.
  assign randomValue     = cap_q;
  assign busy            = (state_q != StIdle);
  assign getRandomNumber = (state_q == StFetch);

endmodule
